seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the CPU's 32-bit syscall display word (disp7seg), driving an 8-digit, common-anode, multiplexed seven-segment display.
- Shows the word as 8 hex digits, one digit per scan slot, with a blanking dead-time at the start of each slot to suppress ghosting.
- New values are double-buffered and applied only at frame boundaries, so the display never shows a torn value.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (must be >= 2).
- BLANK_CYC, 16, dead-time cycles at the start of each slot, all anodes off (must be < SCAN_DIV).
- DP_MASK, 8'h00, per-digit decimal point enable; bit i lights dp on digit i.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- din  input  32  display word; digit i shows din[4i+3:4i].
- din_valid  input  1  single-cycle strobe; captures din into the shadow register.
- freeze  input  1  while high, din_valid is ignored; scanning continues.
- an  output  8  digit anodes, active-low, at most one low at a time.
- seg  output  7  segments a..g on seg[0]..seg[6], active-low.
- dp  output  1  decimal point, active-low.
- pending  output  1  shadow holds a value not yet applied to the display.
- frame_done  output  1  one-cycle pulse when the slot of digit 7 ends.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Outputs: an=8'hFF, seg=7'h7F, dp=1, pending=0, frame_done=0.
  - Internal: div_cnt=0, digit=0, shadow=0, active=0.
- Slot counter div_cnt counts 0..SCAN_DIV-1, then wraps to 0. On wrap, digit increments modulo 8 (7 -> 0).
- Per-slot phases, decided combinationally from div_cnt and digit:
  - BLANK: div_cnt < BLANK_CYC. All anodes off, seg=7'h7F, dp=1.
  - DRIVE: otherwise. an = ~(8'b1 << digit); seg = hex decode of nibble active[4*digit+3:4*digit]; dp = ~DP_MASK[digit].
- an/seg/dp are registered, so they lag the counter state by exactly 1 clk.
- Hex decode (a..g active-high before inversion) follows the standard table:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - seg is the bitwise inverse of the table entry.
- Capture: din_valid && !freeze loads shadow <= din and sets pending <= 1. While pending, a further capture overwrites shadow (last write wins).
- Frame boundary: the edge where digit==7 and div_cnt==SCAN_DIV-1.
  - frame_done is registered high for exactly the following cycle.
  - If pending, active <= shadow and pending <= 0.
- Capture on the same edge as a frame boundary: the transfer uses the shadow value as it stood before that edge. The new din goes into shadow and pending stays 1, so it is applied at the next boundary.
- freeze never affects scanning, the transfer, or an already-pending shadow.
- Reset asserted mid-scan: all state returns to its reset values immediately; scanning restarts at digit 0, div_cnt 0.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: during DRIVE, digit i is blanked (an stays 8'hFF, seg=7'h7F, dp=1) when active[31:4i+4] is all zero and nibble i is zero. Digit 0 is never blanked, so a zero value shows a single "0". DP_MASK is ignored for blanked digits.
- Undefined: all 8 digits are always driven, including leading zeros.

Test Plan (bench uses SCAN_DIV=8, BLANK_CYC=2, DP_MASK=8'h01):
- Reset then 64 cycles with no din_valid -> every DRIVE phase shows seg=7'h40 ("0"), dp=0 on digit 0 only; an never has two bits low; frame_done pulses once every 64 cycles.
- din=32'h01234567, din_valid mid-frame -> pending=1 until the next boundary, then 0. In the following frame, digit0 seg=7'h78 ("7"), digit7 seg=7'h40, digit1 seg=7'h02 ("6").
- Two strobes in one frame (32'hAAAAAAAA then 32'hDEADBEEF) -> only DEADBEEF is displayed, e.g. digit7 seg=7'h21 ("d").
- din_valid on the boundary edge (value 32'hFFFFFFFF) -> old value shown for one more frame, pending=1 throughout, then all digits seg=7'h0E ("F").
- freeze=1 with din_valid, din=32'h12345678 -> shadow unchanged, pending stays 0, display unchanged.
- Reset pulsed during the DRIVE phase of digit 5 -> an=8'hFF and seg=7'h7F immediately (asynchronous). After release, the first DRIVE is digit 0 after 2 blank cycles plus 1 cycle of output latency.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display bus between the word source and the 8-digit seven-segment scan driver.
// The master drives the display word and strobes; the slave drives the panel pins and status.
interface seg7_scan_driver_if;
  logic [31:0] din;
  logic        din_valid;
  logic        freeze;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_done;

  modport master (
    output din, din_valid, freeze,
    input  an, seg, dp, pending, frame_done
  );

  modport slave (
    input  din, din_valid, freeze,
    output an, seg, dp, pending, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed common-anode hex display driver with a double-buffered word and per-slot dead-time.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
  parameter int         SCAN_DIV  = 50000,
  parameter int         BLANK_CYC = 16,
  parameter logic [7:0] DP_MASK   = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_driver_if.slave   bus
);

  localparam int               CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYC);

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_e;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      active_q, active_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  phase_e           phase;
  logic             wrap, boundary, capture, lz_blank;
  logic [3:0]       nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign wrap     = (div_cnt_q == LAST);
  assign boundary = wrap && (digit_q == 3'd7);
  assign capture  = bus.din_valid && !bus.freeze;
  assign phase    = (div_cnt_q < BLANK) ? PH_BLANK : PH_DRIVE;
  assign nibble   = active_q[{digit_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [31:0] upper;
  // Everything above the current nibble; a 6-bit shift lets digit 7 shift the whole word out.
  assign upper    = active_q >> ({1'b0, digit_q, 2'b00} + 6'd4);
  assign lz_blank = (digit_q != 3'd0) && (upper == 32'd0) && (nibble == 4'd0);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    div_cnt_d    = wrap ? '0 : div_cnt_q + CNT_W'(1);
    digit_d      = wrap ? digit_q + 3'd1 : digit_q;
    frame_done_d = boundary;
    shadow_d     = capture ? bus.din : shadow_q;
    // Transfer uses the pre-edge shadow; a same-edge capture stays pending for the next frame.
    active_d     = (boundary && pending_q) ? shadow_q : active_q;
    pending_d    = capture ? 1'b1 : (boundary ? 1'b0 : pending_q);

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (phase == PH_DRIVE && !lz_blank) begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = ~hex7(nibble);
      dp_d  = ~DP_MASK[digit_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q    <= '0;
      digit_q      <= 3'd0;
      shadow_q     <= 32'd0;
      active_q     <= 32'd0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues the expected digit of every scan slot,
// a monitor pops and compares at each slot start and tracks frame_done spacing and anode exclusivity.
module tb_seg7_scan_driver;
  localparam int         SCAN_DIV  = 8;
  localparam int         BLANK_CYC = 2;
  localparam logic [7:0] DP_MASK   = 8'h01;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .DP_MASK  (DP_MASK)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         digit;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   onehot_err = 0;

  // Active-low segment patterns for hex digits 0..F, worked out by hand.
  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_frame(input logic [31:0] v);
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      e.an    = ~(8'h01 << d);
      e.seg   = segtab[v[4*d +: 4]];
      e.dp    = ~DP_MASK[d];
      e.digit = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic strobe(input logic [31:0] v);
    bus.din       = v;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.frame_done !== 1'b1) begin
      n_checks++;
      $display("FAIL %s frame_done timeout: got 0 expected 1", tag);
    end
  endtask

  // Monitor: compares each slot as it begins driving, checks frame_done spacing.
  initial begin
    logic [7:0] prev_an, lo;
    exp_t       e;
    int         cyc, fd_cyc;
    bit         fd_seen;
    prev_an = 8'hFF;
    cyc     = 0;
    fd_cyc  = 0;
    fd_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_an = 8'hFF;
        fd_seen = 1'b0;
      end else begin
        cyc++;
        lo = ~bus.an;
        if ((lo & (lo - 8'd1)) != 8'd0) onehot_err++;
        if (bus.an !== 8'hFF && prev_an === 8'hFF) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL slot_unexpected: got an=%h expected no drive", bus.an);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("slot%0d_an", e.digit),  32'(bus.an),  32'(e.an));
            chk($sformatf("slot%0d_seg", e.digit), 32'(bus.seg), 32'(e.seg));
            chk($sformatf("slot%0d_dp", e.digit),  32'(bus.dp),  32'(e.dp));
          end
        end
        prev_an = bus.an;
        if (bus.frame_done === 1'b1) begin
          if (fd_seen) chk("fd_period", 32'(cyc - fd_cyc), 32'd64);
          fd_seen = 1'b1;
          fd_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    bus.din       = 32'd0;
    bus.din_valid = 1'b0;
    bus.freeze    = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an",   32'(bus.an),         32'hFF);
    chk("rst_seg",  32'(bus.seg),        32'h7F);
    chk("rst_dp",   32'(bus.dp),         32'h1);
    chk("rst_pend", 32'(bus.pending),    32'h0);
    chk("rst_fd",   32'(bus.frame_done), 32'h0);
    expect_frame(32'h0);
    rst_n = 1'b1;

    // Frame 1: idle, shows zeros.
    wait_fd("f1");
    chk("f1_pend", 32'(bus.pending), 32'h0);
    expect_frame(32'h0);

    // Frame 2: single mid-frame capture.
    repeat (20) @(negedge clk);
    strobe(32'h01234567);
    chk("cap_pend_set", 32'(bus.pending), 32'h1);
    wait_fd("f2");
    chk("cap_pend_clr", 32'(bus.pending), 32'h0);
    expect_frame(32'h01234567);

    // Frame 3: two captures, last wins.
    repeat (10) @(negedge clk);
    strobe(32'hAAAAAAAA);
    repeat (5) @(negedge clk);
    strobe(32'hDEADBEEF);
    chk("dbl_pend_set", 32'(bus.pending), 32'h1);
    wait_fd("f3");
    chk("dbl_pend_clr", 32'(bus.pending), 32'h0);
    expect_frame(32'hDEADBEEF);

    // Frame 4: capture on the boundary edge itself.
    repeat (63) @(negedge clk);
    bus.din       = 32'hFFFFFFFF;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    chk("bnd_fd",   32'(bus.frame_done), 32'h1);
    chk("bnd_pend", 32'(bus.pending),    32'h1);
    expect_frame(32'hDEADBEEF);
    repeat (30) @(negedge clk);
    chk("bnd_pend_hold", 32'(bus.pending), 32'h1);
    wait_fd("f5");
    chk("bnd_pend_clr", 32'(bus.pending), 32'h0);
    expect_frame(32'hFFFFFFFF);

    // Frame 6: freeze blocks capture.
    repeat (20) @(negedge clk);
    bus.freeze = 1'b1;
    strobe(32'h12345678);
    chk("frz_pend", 32'(bus.pending), 32'h0);
    repeat (5) @(negedge clk);
    bus.freeze = 1'b0;
    wait_fd("f6");
    chk("frz_pend_fd", 32'(bus.pending), 32'h0);
    expect_frame(32'hFFFFFFFF);
    wait_fd("f7");
    expect_frame(32'hFFFFFFFF);

    // Frame 8: asynchronous reset during digit 5 drive.
    repeat (44) @(negedge clk);
    chk("pre_rst_an", 32'(bus.an), 32'hDF);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_an",  32'(bus.an),  32'hFF);
    chk("arst_seg", 32'(bus.seg), 32'h7F);
    chk("arst_dp",  32'(bus.dp),  32'h1);
    exp_q.delete();
    @(negedge clk);
    chk("arst_pend", 32'(bus.pending), 32'h0);
    expect_frame(32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_blank0", 32'(bus.an), 32'hFF);
    @(negedge clk);
    chk("rel_blank1", 32'(bus.an), 32'hFF);
    @(negedge clk);
    chk("rel_first_an",  32'(bus.an),  32'hFE);
    chk("rel_first_seg", 32'(bus.seg), 32'h40);
    wait_fd("f9");
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("anode_onehot",  32'(onehot_err),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
